// File: rtl/priority_irq_controller.sv
// Eight-source, fixed-priority interrupt controller with rising-edge capture,
// per-source masking and a non-preemptive IDLE/SERVE/CLEAR handshake.
module priority_irq_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       ack,
    output logic       irq,
    output logic [2:0] vector,
    output logic [7:0] pending
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic [1:0] state_reg, state_next;
    logic [7:0] req_d_reg;
    logic [7:0] pending_reg, pending_next;
    logic [7:0] mask_reg, mask_next;
    logic [7:0] edge_det;
    logic [7:0] eligible;
    logic [7:0] clr_onehot;
    logic [2:0] vector_reg, vector_next;
    logic [2:0] sel_idx;
    logic       sel_valid;
    logic       irq_reg, irq_next;

    assign edge_det  = req & ~req_d_reg;
    assign eligible  = pending_reg & ~mask_reg;
    assign mask_next = mask_we ? mask_wdata : mask_reg;

    // A fresh edge wins over the clear of the same bit, so a source that
    // re-fires while its service is being retired is not lost.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pending
            assign clr_onehot[gi]   = (state_reg == CLEAR) && (vector_reg == 3'(gi));
            assign pending_next[gi] = edge_det[gi] | (pending_reg[gi] & ~clr_onehot[gi]);
        end
    endgenerate

    // Scanning from the top down leaves the lowest set index selected.
    always_comb begin
        sel_idx   = 3'd0;
        sel_valid = |eligible;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        vector_next = vector_reg;
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    state_next  = SERVE;
                    vector_next = sel_idx;
                end
            end
            SERVE: begin
                if (ack) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        irq_next = (state_next == SERVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_d_reg   <= req;
            state_reg   <= IDLE;
            irq_reg     <= 1'b0;
            vector_reg  <= 3'd0;
            pending_reg <= 8'h00;
            mask_reg    <= 8'h00;
        end else begin
            req_d_reg   <= req;
            state_reg   <= state_next;
            irq_reg     <= irq_next;
            vector_reg  <= vector_next;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
        end
    end

    assign irq     = irq_reg;
    assign vector  = vector_reg;
    assign pending = pending_reg;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Directed scenarios plus randomized traffic for priority_irq_controller,
// checked every cycle against a behavioural model of the controller.
module tb_priority_irq_controller;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       irq;
    logic [2:0] vector;
    logic [7:0] pending;

    int checks   = 0;
    int failures = 0;

    priority_irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .irq        (irq),
        .vector     (vector),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: a pending set, a mask, and a service phase
    // (0 = waiting, 1 = handler busy with m_vec, 2 = retiring m_vec).
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    int         m_phase;
    int         m_vec;
    bit         m_init = 1'b0;

    function automatic int lowest_set(input logic [7:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [7:0] rises;
        logic [7:0] elig;
        logic [7:0] next_pend;
        if (reset) begin
            m_pend  = 8'h00;
            m_mask  = 8'h00;
            m_prev  = req;
            m_phase = 0;
            m_vec   = 0;
            m_init  = 1'b1;
        end else if (m_init) begin
            rises     = req & ~m_prev;
            m_prev    = req;
            elig      = m_pend & ~m_mask;
            next_pend = m_pend | rises;
            if (m_phase == 0) begin
                if (elig != 8'h00) begin
                    m_vec   = lowest_set(elig);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ack) m_phase = 2;
            end else begin
                if (!rises[m_vec]) next_pend[m_vec] = 1'b0;
                m_phase = 0;
            end
            if (mask_we) m_mask = mask_wdata;
            m_pend = next_pend;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            check("model_irq", {7'd0, irq}, (m_phase == 1) ? 8'h01 : 8'h00);
            check("model_pending", pending, m_pend);
            if (m_phase == 1) check("model_vector", {5'd0, vector}, 8'(m_vec));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic serve_ack();
        ack = 1'b1;
        step();
        check("ack_drops_irq", {7'd0, irq}, 8'h00);
        ack = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; req = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0;
        step(); step();
        reset = 1'b0;
        check("reset_irq", {7'd0, irq}, 8'h00);
        check("reset_vector", {5'd0, vector}, 8'h00);
        check("reset_pending", pending, 8'h00);
        $display("txn reset done");

        // Single source
        req = 8'h08; step();
        check("single_pending", pending, 8'h08);
        check("single_irq_early", {7'd0, irq}, 8'h00);
        step();
        check("single_irq", {7'd0, irq}, 8'h01);
        check("single_vector", {5'd0, vector}, 8'h03);
        serve_ack();
        check("single_cleared", pending, 8'h00);
        req = 8'h00; step();
        $display("txn single source done");

        // Fixed priority order
        req = 8'hA4; step();
        check("prio_pending", pending, 8'hA4);
        step();
        check("prio_vec2", {5'd0, vector}, 8'h02);
        serve_ack();
        check("prio_pend_a0", pending, 8'hA0);
        step();
        check("prio_vec5", {5'd0, vector}, 8'h05);
        serve_ack();
        check("prio_pend_80", pending, 8'h80);
        step();
        check("prio_vec7", {5'd0, vector}, 8'h07);
        serve_ack();
        check("prio_pend_00", pending, 8'h00);
        req = 8'h00; step();
        $display("txn priority done");

        // Mask holds source 0 back while source 1 is served
        mask_we = 1'b1; mask_wdata = 8'h01; step();
        mask_we = 1'b0;
        req = 8'h03; step();
        check("mask_pending", pending, 8'h03);
        step();
        check("mask_vec1", {5'd0, vector}, 8'h01);
        serve_ack();
        check("mask_pend_kept", pending, 8'h01);
        step();
        check("mask_no_irq", {7'd0, irq}, 8'h00);
        mask_we = 1'b1; mask_wdata = 8'h00; step();
        mask_we = 1'b0; step();
        check("unmask_irq", {7'd0, irq}, 8'h01);
        check("unmask_vec0", {5'd0, vector}, 8'h00);
        serve_ack();
        req = 8'h00; step();
        $display("txn mask done");

        // No preemption
        req = 8'h40; step(); step();
        check("nopre_vec6", {5'd0, vector}, 8'h06);
        req = 8'h41; step(); step();
        check("nopre_hold_irq", {7'd0, irq}, 8'h01);
        check("nopre_hold_vec", {5'd0, vector}, 8'h06);
        serve_ack();
        step();
        check("nopre_vec0_irq", {7'd0, irq}, 8'h01);
        check("nopre_vec0", {5'd0, vector}, 8'h00);
        serve_ack();
        req = 8'h00; step();
        $display("txn no-preemption done");

        // Re-edge during CLEAR keeps the source pending
        req = 8'h20; step(); step();
        check("coll_vec5", {5'd0, vector}, 8'h05);
        req = 8'h00; step();
        ack = 1'b1; step();
        ack = 1'b0; req = 8'h20; step();
        check("coll_pending", pending, 8'h20);
        step();
        check("coll_irq", {7'd0, irq}, 8'h01);
        check("coll_vec", {5'd0, vector}, 8'h05);
        serve_ack();
        req = 8'h00; step();
        $display("txn set/clear collision done");

        // Reset aborts service; held lines do not re-trigger
        req = 8'hFF; step(); step();
        check("rst_pre_irq", {7'd0, irq}, 8'h01);
        reset = 1'b1; mask_we = 1'b1; mask_wdata = 8'hFF; ack = 1'b1; step();
        reset = 1'b0; mask_we = 1'b0; ack = 1'b0;
        check("rst_irq", {7'd0, irq}, 8'h00);
        check("rst_pending", pending, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_quiet_irq", {7'd0, irq}, 8'h00);
        end
        // Mask was cleared by reset, so a new edge on source 4 must be served
        req = 8'hEF; step(); req = 8'hFF; step(); step();
        check("rst_mask_clear", {5'd0, vector}, 8'h04);
        serve_ack();
        req = 8'h00; step();
        $display("txn reset mid-service done");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req        = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom);
            ack        = ($urandom_range(0, 2) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; ack = 1'b0; mask_we = 1'b0;
        step();
        $display("txn random traffic done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
